// File: rtl/rns_mac_32_31_21_5_if.sv
`default_nettype none
// ============================================================================
// Module   : rns_mac_32_31_21_5_if
// Brief    : Beat-input / frame-result bus of the RNS (32,31,21,5) MAC.
//            master = producer/consumer side, slave = the MAC itself.
// Revision : 1.0  initial release
// ============================================================================
interface rns_mac_32_31_21_5_if #(
   parameter int CNT_W = 8
);
   // input beat channel
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       a0, b0;      // mod 32
   logic [4:0]       a1, b1;      // mod 31
   logic [4:0]       a2, b2;      // mod 21
   logic [2:0]       a3, b3;      // mod 5
   // frame result channel
   logic             out_valid;
   logic             out_ready;
   logic [4:0]       x0, x1, x2;
   logic [2:0]       x3;
   // frame progress
   logic [CNT_W-1:0] beat_cnt;

   modport master (
      output in_valid, a0, b0, a1, b1, a2, b2, a3, b3, out_ready,
      input  in_ready, out_valid, x0, x1, x2, x3, beat_cnt
   );

   modport slave (
      input  in_valid, a0, b0, a1, b1, a2, b2, a3, b3, out_ready,
      output in_ready, out_valid, x0, x1, x2, x3, beat_cnt
   );
endinterface
`default_nettype wire

// File: rtl/rns_mac_32_31_21_5.sv
`default_nettype none
// ============================================================================
// Module   : rns_mac_32_31_21_5
// Brief    : Residue-domain multiply-accumulate over frames of FRAME_LEN beats
//            for moduli (32, 31, 21, 5). S1 registers raw products, S2
//            registers reduced products, then a modular add into the channel
//            accumulators; the last beat of a frame loads the output register.
// Revision : 1.0  initial release
// ============================================================================
module rns_mac_32_31_21_5 #(
   parameter int FRAME_LEN = 4,
   parameter int CNT_W     = 8
) (
   input  logic                  clk,
   input  logic                  reset,   // asynchronous, active-low
   rns_mac_32_31_21_5_if.slave   bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   // ---------------------------------------------------------------------
   // Residue arithmetic helpers
   // ---------------------------------------------------------------------

   // Two end-around folds (2^5 == 1 mod 31), then 31 -> 0.
   function automatic logic [4:0] red31(input logic [9:0] p);
      logic [5:0] f1;
      logic [5:0] f2;
      f1 = {1'b0, p[9:5]} + {1'b0, p[4:0]};
      f2 = {5'b0, f1[5]} + {1'b0, f1[4:0]};
      if (f2 >= 6'd31) begin
         f2 = f2 - 6'd31;
      end
      return f2[4:0];
   endfunction

   // Chained conditional subtraction of 21*2^k; exact for any 10-bit value.
   function automatic logic [4:0] red21(input logic [9:0] p);
      logic [9:0] t;
      t = p;
      if (t >= 10'd672) t = t - 10'd672;
      if (t >= 10'd336) t = t - 10'd336;
      if (t >= 10'd168) t = t - 10'd168;
      if (t >= 10'd84)  t = t - 10'd84;
      if (t >= 10'd42)  t = t - 10'd42;
      if (t >= 10'd21)  t = t - 10'd21;
      return t[4:0];
   endfunction

   // Chained conditional subtraction of 5*2^k; exact for any 6-bit value.
   function automatic logic [2:0] red5(input logic [5:0] p);
      logic [5:0] t;
      t = p;
      if (t >= 6'd40) t = t - 6'd40;
      if (t >= 6'd20) t = t - 6'd20;
      if (t >= 6'd10) t = t - 6'd10;
      if (t >= 6'd5)  t = t - 6'd5;
      return t[2:0];
   endfunction

   // Modular add of two canonical 5-bit residues (modulus up to 32).
   function automatic logic [4:0] add_mod5(input logic [4:0] x, input logic [4:0] y,
                                           input logic [5:0] m);
      logic [5:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= m) begin
         s = s - m;
      end
      return s[4:0];
   endfunction

   // Modular add of two canonical residues mod 5.
   function automatic logic [2:0] add_mod3(input logic [2:0] x, input logic [2:0] y);
      logic [3:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= 4'd5) begin
         s = s - 4'd5;
      end
      return s[2:0];
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

   logic             s1_valid_q, s1_valid_d;
   logic             s1_last_q,  s1_last_d;
   logic [9:0]       p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
   logic [5:0]       p3_q, p3_d;

   logic             s2_valid_q, s2_valid_d;
   logic             s2_last_q,  s2_last_d;
   logic [4:0]       r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
   logic [2:0]       r3_q, r3_d;

   logic [4:0]       acc0_q, acc0_d, acc1_q, acc1_d, acc2_q, acc2_d;
   logic [2:0]       acc3_q, acc3_d;

   logic             out_valid_q, out_valid_d;
   logic [4:0]       x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
   logic [2:0]       x3_q, x3_d;

   // ---------------------------------------------------------------------
   // Combinational datapath
   // ---------------------------------------------------------------------
   logic             stall;
   logic             accept;
   logic             beat_last;
   logic [4:0]       sum0, sum1, sum2;
   logic [2:0]       sum3;

   // A held result that the consumer has not taken freezes the whole pipe.
   assign stall     = out_valid_q & ~bus.out_ready;
   assign accept    = bus.in_valid & ~stall;
   assign beat_last = (beat_cnt_q == LAST_CNT);

   // Accumulator plus the reduced product leaving S2.
   assign sum0 = add_mod5(acc0_q, r0_q, 6'd32);
   assign sum1 = add_mod5(acc1_q, r1_q, 6'd31);
   assign sum2 = add_mod5(acc2_q, r2_q, 6'd21);
   assign sum3 = add_mod3(acc3_q, r3_q);

   assign bus.in_ready  = ~stall;
   assign bus.out_valid = out_valid_q;
   assign bus.x0        = x0_q;
   assign bus.x1        = x1_q;
   assign bus.x2        = x2_q;
   assign bus.x3        = x3_q;
   assign bus.beat_cnt  = beat_cnt_q;

   // Next-state: frame counter, S1 products, S2 reductions, accumulate, output.
   always_comb begin
      beat_cnt_d  = beat_cnt_q;
      s1_valid_d  = s1_valid_q;
      s1_last_d   = s1_last_q;
      p0_d        = p0_q;
      p1_d        = p1_q;
      p2_d        = p2_q;
      p3_d        = p3_q;
      s2_valid_d  = s2_valid_q;
      s2_last_d   = s2_last_q;
      r0_d        = r0_q;
      r1_d        = r1_q;
      r2_d        = r2_q;
      r3_d        = r3_q;
      acc0_d      = acc0_q;
      acc1_d      = acc1_q;
      acc2_d      = acc2_q;
      acc3_d      = acc3_q;
      out_valid_d = out_valid_q;
      x0_d        = x0_q;
      x1_d        = x1_q;
      x2_d        = x2_q;
      x3_d        = x3_q;

      if (!stall) begin
         // S1: capture raw products of an accepted beat
         s1_valid_d = accept;
         if (accept) begin
            p0_d      = {5'b0, bus.a0} * {5'b0, bus.b0};
            p1_d      = {5'b0, bus.a1} * {5'b0, bus.b1};
            p2_d      = {5'b0, bus.a2} * {5'b0, bus.b2};
            p3_d      = {3'b0, bus.a3} * {3'b0, bus.b3};
            s1_last_d = beat_last;
            beat_cnt_d = beat_last ? '0 : beat_cnt_q + 1'b1;
         end

         // S2: reduce each product into its canonical residue
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_last_d = s1_last_q;
            r0_d      = p0_q[4:0];
            r1_d      = red31(p1_q);
            r2_d      = red21(p2_q);
            r3_d      = red5(p3_q);
         end

         // Not stalled means any held result is being taken this edge.
         out_valid_d = 1'b0;

         // Accumulate; the last beat publishes the sum and restarts from 0.
         if (s2_valid_q) begin
            if (s2_last_q) begin
               x0_d        = sum0;
               x1_d        = sum1;
               x2_d        = sum2;
               x3_d        = sum3;
               out_valid_d = 1'b1;
               acc0_d      = '0;
               acc1_d      = '0;
               acc2_d      = '0;
               acc3_d      = '0;
            end else begin
               acc0_d = sum0;
               acc1_d = sum1;
               acc2_d = sum2;
               acc3_d = sum3;
            end
         end
      end
   end

   // State register; reset discards partial sums, pipeline and pending result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_cnt_q  <= '0;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         p0_q        <= '0;
         p1_q        <= '0;
         p2_q        <= '0;
         p3_q        <= '0;
         s2_valid_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         r0_q        <= '0;
         r1_q        <= '0;
         r2_q        <= '0;
         r3_q        <= '0;
         acc0_q      <= '0;
         acc1_q      <= '0;
         acc2_q      <= '0;
         acc3_q      <= '0;
         out_valid_q <= 1'b0;
         x0_q        <= '0;
         x1_q        <= '0;
         x2_q        <= '0;
         x3_q        <= '0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         s1_valid_q  <= s1_valid_d;
         s1_last_q   <= s1_last_d;
         p0_q        <= p0_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
         p3_q        <= p3_d;
         s2_valid_q  <= s2_valid_d;
         s2_last_q   <= s2_last_d;
         r0_q        <= r0_d;
         r1_q        <= r1_d;
         r2_q        <= r2_d;
         r3_q        <= r3_d;
         acc0_q      <= acc0_d;
         acc1_q      <= acc1_d;
         acc2_q      <= acc2_d;
         acc3_q      <= acc3_d;
         out_valid_q <= out_valid_d;
         x0_q        <= x0_d;
         x1_q        <= x1_d;
         x2_q        <= x2_d;
         x3_q        <= x3_d;
      end
   end

endmodule
`default_nettype wire
